// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the generator-sequence monitor:
// code constants, FSM states and the code-to-position mapping.
package fsm_seq_pkg;

  localparam logic [2:0] C_S0 = 3'b000;
  localparam logic [2:0] C_S1 = 3'b001;
  localparam logic [2:0] C_S2 = 3'b011;
  localparam logic [2:0] C_S3 = 3'b101;
  localparam logic [2:0] C_S4 = 3'b111;
  localparam logic [2:0] C_S5 = 3'b010;
  localparam logic [2:0] C_IL_A = 3'b100;
  localparam logic [2:0] C_IL_B = 3'b110;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LOCKED
  } state_e;

  typedef enum logic [1:0] {
    CL_HOLD,
    CL_NEXT,
    CL_SKIP,
    CL_ILL
  } cls_e;

  function automatic logic [3:0] code_to_idx(
    input logic [2:0] code
  );
    logic [3:0] r;
    unique case (code)
      C_S0:    r = {1'b1, 3'd0};
      C_S1:    r = {1'b1, 3'd1};
      C_S2:    r = {1'b1, 3'd2};
      C_S3:    r = {1'b1, 3'd3};
      C_S4:    r = {1'b1, 3'd4};
      C_S5:    r = {1'b1, 3'd5};
      default: r = {1'b0, 3'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_code_decode.sv
// Combinational code -> {legal, position} decoder, reusable
// by any monitor watching the generator state vector.
module seq_code_decode
  import fsm_seq_pkg::*;
(
  input  logic [2:0] code,
  output logic       legal,
  output logic [2:0] idx
);

  always_comb begin
    {legal, idx} = code_to_idx(code);
  end

endmodule

// File: rtl/fsm_seq_checker.sv
// Lock/track monitor for the six-state cyclic generator code:
// classifies each valid sample, runs HUNT/SYNC/LOCKED, counts laps.
module fsm_seq_checker
  import fsm_seq_pkg::*;
#(
  parameter int LOCK_N   = 2,
  parameter int MISS_MAX = 3,
  parameter int LAP_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       code,
  input  logic             lap_clr,
  output logic             locked,
  output logic [2:0]       index,
  output logic             seq_err,
  output logic             illegal_err,
  output logic [LAP_W-1:0] lap_count
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  state_e           state_q, state_d;
  logic [2:0]       index_q, index_d;
  logic [GW-1:0]    good_q, good_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             seq_err_q, seq_err_d;
  logic             ill_err_q, ill_err_d;

  logic       legal;
  logic [2:0] code_idx;
  logic [2:0] next_idx;
  cls_e       cls;

  seq_code_decode u_dec (
    .code  (code),
    .legal (legal),
    .idx   (code_idx)
  );

  assign next_idx = (index_q == 3'd5) ? 3'd0 : index_q + 3'd1;

  always_comb begin
    cls = CL_SKIP;
    unique case (1'b1)
      !legal:                         cls = CL_ILL;
      legal && code_idx == index_q:  cls = CL_HOLD;
      legal && code_idx == next_idx: cls = CL_NEXT;
      default:                        cls = CL_SKIP;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    good_d    = good_q;
    miss_d    = miss_q;
    lap_d     = lap_q;
    seq_err_d = 1'b0;
    ill_err_d = 1'b0;
    if (valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (cls == CL_ILL) begin
            ill_err_d = 1'b1;
          end else begin
            index_d = code_idx;
            good_d  = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          unique case (cls)
            CL_HOLD: ;
            CL_NEXT: begin
              index_d = next_idx;
              good_d  = good_q + 1'b1;
              if (good_d == GW'(LOCK_N)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end
            CL_SKIP: begin
              index_d = code_idx;
              good_d  = '0;
            end
            CL_ILL: begin
              ill_err_d = 1'b1;
              state_d   = ST_HUNT;
            end
            default: ;
          endcase
        end
        ST_LOCKED: begin
          unique case (cls)
            CL_HOLD: ;
            CL_NEXT: begin
              index_d = next_idx;
              miss_d  = '0;
              if (index_q == 3'd5 && lap_q != '1) begin
                lap_d = lap_q + 1'b1;
              end
            end
            CL_SKIP: begin
              seq_err_d = 1'b1;
              index_d   = code_idx;
              miss_d    = miss_q + 1'b1;
            end
            CL_ILL: begin
              seq_err_d = 1'b1;
              ill_err_d = 1'b1;
              miss_d    = miss_q + 1'b1;
            end
            default: ;
          endcase
          // lock drops on the same edge that raises the final error
          if (miss_d == MW'(MISS_MAX)) begin
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (lap_clr) begin
      lap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      index_q   <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      lap_q     <= '0;
      seq_err_q <= 1'b0;
      ill_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      lap_q     <= lap_d;
      seq_err_q <= seq_err_d;
      ill_err_q <= ill_err_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign index       = index_q;
  assign seq_err     = seq_err_q;
  assign illegal_err = ill_err_q;
  assign lap_count   = lap_q;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Self-checking bench: directed vector table, hand sequences
// for reset/saturation, and random traffic against a model.
module tb_fsm_seq_checker;

  localparam int LOCK_N   = 2;
  localparam int MISS_MAX = 3;
  localparam int LAP_W    = 3;
  localparam int LAP_MAX  = (1 << LAP_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid;
  logic [2:0]       code;
  logic             lap_clr;
  logic             locked;
  logic [2:0]       index;
  logic             seq_err;
  logic             illegal_err;
  logic [LAP_W-1:0] lap_count;

  fsm_seq_checker #(
    .LOCK_N   (LOCK_N),
    .MISS_MAX (MISS_MAX),
    .LAP_W    (LAP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .code        (code),
    .lap_clr     (lap_clr),
    .locked      (locked),
    .index       (index),
    .seq_err     (seq_err),
    .illegal_err (illegal_err),
    .lap_count   (lap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       clr;
    logic       e_lock;
    logic [2:0] e_idx;
    logic       e_seq;
    logic       e_ill;
    int         e_lap;
  } vec_t;

  vec_t tbl[$];

  logic [2:0] seq_tab [6] = '{3'b000, 3'b001, 3'b011,
                              3'b101, 3'b111, 3'b010};

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: plain positions and a mode number
  int m_mode;  // 0 hunting, 1 syncing, 2 locked
  int m_idx, m_good, m_miss, m_lap;
  bit m_seq, m_ill;

  function automatic int pos_of(logic [2:0] c);
    for (int k = 0; k < 6; k++) if (seq_tab[k] == c) return k;
    return -1;
  endfunction

  task automatic model_step(bit v, logic [2:0] c, bit clr, bit rst);
    int p;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_good = 0; m_miss = 0; m_lap = 0;
      m_seq = 0; m_ill = 0;
      return;
    end
    m_seq = 0;
    m_ill = 0;
    if (v) begin
      p = pos_of(c);
      if (m_mode == 0) begin
        if (p < 0) m_ill = 1;
        else begin m_idx = p; m_good = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (p < 0) begin m_ill = 1; m_mode = 0; end
        else if (p == (m_idx + 1) % 6) begin
          m_idx = p; m_good++;
          if (m_good == LOCK_N) begin m_mode = 2; m_miss = 0; end
        end else if (p != m_idx) begin
          m_idx = p; m_good = 0;
        end
      end else begin
        if (p < 0) begin m_seq = 1; m_ill = 1; m_miss++; end
        else if (p == (m_idx + 1) % 6) begin
          if (p == 0 && m_lap < LAP_MAX) m_lap++;
          m_idx = p; m_miss = 0;
        end else if (p != m_idx) begin
          m_seq = 1; m_idx = p; m_miss++;
        end
        if (m_miss == MISS_MAX) m_mode = 0;
      end
    end
    if (clr) m_lap = 0;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic apply(bit v, logic [2:0] c, bit clr, bit rst);
    @(negedge clk);
    valid = v; code = c; lap_clr = clr; reset = rst;
    @(posedge clk);
    #1;
    model_step(v, c, clr, rst);
  endtask

  task automatic chk_exp(string nm, bit lk, int ix, bit se,
                         bit ie, int lp);
    chk({nm, ".locked"}, int'(locked), int'(lk));
    chk({nm, ".index"}, int'(index), ix);
    chk({nm, ".seq_err"}, int'(seq_err), int'(se));
    chk({nm, ".illegal_err"}, int'(illegal_err), int'(ie));
    chk({nm, ".lap_count"}, int'(lap_count), lp);
  endtask

  task automatic chk_model(string nm);
    chk_exp(nm, m_mode == 2, m_idx, m_seq, m_ill, m_lap);
  endtask

  task automatic add(bit v, logic [2:0] c, bit clr, bit lk,
                     int ix, bit se, bit ie, int lp);
    vec_t e;
    e.v = v; e.c = c; e.clr = clr; e.e_lock = lk;
    e.e_idx = 3'(ix); e.e_seq = se; e.e_ill = ie; e.e_lap = lp;
    tbl.push_back(e);
  endtask

  initial begin
    int g, r;
    logic [2:0] c;
    bit v, clr;

    valid = 0; code = 0; lap_clr = 0; reset = 1;

    // clean lock and stall tolerance
    add(1, 3'b000, 0, 0, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 1, 0, 0, 0);
    add(1, 3'b011, 0, 1, 2, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(1, 3'b011, 0, 1, 2, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 3'b100, 0, 1, 2, 0, 0, 0);
    add(1, 3'b101, 0, 1, 3, 0, 0, 0);
    // three laps, then a wrap with lap_clr
    add(1, 3'b111, 0, 1, 4, 0, 0, 0);
    add(1, 3'b010, 0, 1, 5, 0, 0, 0);
    add(1, 3'b000, 0, 1, 0, 0, 0, 1);
    for (int l = 2; l <= 4; l++) begin
      for (int k = 1; k < 6; k++)
        add(1, seq_tab[k], 0, 1, k, 0, 0, l - 1);
      add(1, 3'b000, l == 4, 1, 0, 0, 0, l == 4 ? 0 : l);
    end
    // skip then recovery
    add(1, 3'b001, 0, 1, 1, 0, 0, 0);
    add(1, 3'b111, 0, 1, 4, 1, 0, 0);
    add(1, 3'b010, 0, 1, 5, 0, 0, 0);
    // three illegal codes drop lock
    add(1, 3'b100, 0, 1, 5, 1, 1, 0);
    add(1, 3'b110, 0, 1, 5, 1, 1, 0);
    add(1, 3'b100, 0, 0, 5, 1, 1, 0);
    // back in hunt: illegal flags only, then relock
    add(1, 3'b110, 0, 0, 5, 0, 1, 0);
    add(1, 3'b000, 0, 0, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 1, 0, 0, 0);
    add(1, 3'b011, 0, 1, 2, 0, 0, 0);

    apply(0, 3'b000, 0, 1);
    chk_exp("reset", 0, 0, 0, 0, 0);
    apply(0, 3'b000, 0, 0);
    chk_exp("idle", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].c, tbl[i].clr, 0);
      chk_exp($sformatf("vec%0d", i), tbl[i].e_lock,
              int'(tbl[i].e_idx), tbl[i].e_seq, tbl[i].e_ill,
              tbl[i].e_lap);
    end

    // five laps, then reset together with a NEXT sample
    for (int k = 0; k < 30; k++) begin
      apply(1, seq_tab[(m_idx + 1) % 6], 0, 0);
      chk_model("laps");
    end
    chk("laps.five", int'(lap_count), 5);
    apply(1, seq_tab[(m_idx + 1) % 6], 1, 1);
    chk_exp("midreset", 0, 0, 0, 0, 0);

    // lap counter saturation
    for (int k = 0; k < 60; k++) begin
      apply(1, seq_tab[k % 6], 0, 0);
      chk_model("sat");
    end
    chk("sat.max", int'(lap_count), LAP_MAX);

    // random traffic against the model
    g = m_idx;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      v = 1;
      clr = 0;
      if (r < 10) begin
        v = 0;
        c = 3'($urandom);
      end else if (r < 62) begin
        g = (g + 1) % 6;
        c = seq_tab[g];
      end else if (r < 76) begin
        c = seq_tab[g];
      end else if (r < 90) begin
        g = $urandom_range(0, 5);
        c = seq_tab[g];
      end else begin
        c = $urandom_range(0, 1) ? 3'b100 : 3'b110;
      end
      if (v && $urandom_range(0, 59) == 0) clr = 1;
      apply(v, c, clr, 0);
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
